sc_dmem_mmio: RTL
=================

Name: sc_dmem_mmio

Overview:
- Data-memory stage directly downstream of the single-cycle CPU core.
- Consumes the core's ALU address, store data and write-enable; returns read data on the core's memory input in the same cycle.
- Contains a word-addressed data RAM plus a memory-mapped I/O window: byte transmit FIFO with valid/ready drain, status register, LED register and free-running cycle counter.

Parameters:
- RAM_AW, 10, RAM word-address width (RAM depth = 2**RAM_AW words of 32 bits).
- FIFO_DEPTH, 4, transmit FIFO entries; power of two, minimum 2.
- FIFO_AW, 2, log2(FIFO_DEPTH).

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- resetn  input  1  synchronous, active-low reset.
- addr  input  32  byte address from the core's ALU output.
- datain  input  32  store data from the core's register-file B output.
- we  input  1  store enable from the core's memory-write control.
- dataout  output  32  load data to the core's memory input; combinational.
- tx_data  output  8  FIFO head byte.
- tx_valid  output  1  FIFO non-empty.
- tx_ready  input  1  consumer accepts tx_data this cycle.
- led  output  8  LED register.

Behaviour:
- One clock (clock); reset is synchronous and active-low (resetn); sampled only on the rising clock edge.
- Reset values:
  - tx_valid=0, tx_data=0, led=0.
  - FIFO count, read and write pointers = 0.
  - Overflow flag = 0; cycle counter = 0.
  - RAM contents are not reset.
- Decode uses addr[31:28]:
  - 4'h0: RAM. Word index = addr[RAM_AW+1:2]; addr[1:0] ignored; upper index bits ignored (aliasing).
  - 4'hF: I/O. Register = addr[3:2]; addr[27:4] ignored.
  - Any other region: reads return 0; writes are ignored.
- RAM:
  - Read is combinational (zero latency), as the single-cycle core requires.
  - Write happens at the rising edge when we=1.
  - Read and write of the same word in one cycle: dataout shows the old value; the new value is visible the next cycle.
- I/O registers:
  - 0xF0000000 TXDATA
    - Write pushes datain[7:0].
    - Read returns {24'b0, head byte} when non-empty, 0 when empty; reads never pop.
  - 0xF0000004 STATUS
    - Read returns {28'b0, overflow, full, empty, 1'b0}.
    - Any write clears overflow.
  - 0xF0000008 CYCLES
    - Read returns the counter.
    - Any write loads 0 at the edge; that write has priority over the increment.
  - 0xF000000C LED
    - Write loads datain[7:0].
    - Read returns {24'b0, led}.
- FIFO:
  - pop = tx_valid & tx_ready.
  - push_req = we & TXDATA selected.
  - Push is accepted when count<FIFO_DEPTH, or when a pop occurs in the same cycle (full with simultaneous pop: both happen, count unchanged).
  - Rejected push: data dropped, overflow set (sticky). A rejected push and a STATUS write cannot coincide, since there is one address per cycle.
  - Empty with simultaneous push: no pop (tx_valid=0); byte appears on tx_data with tx_valid=1 the next cycle.
  - Pointers wrap modulo FIFO_DEPTH; count width is FIFO_AW+1.
  - full = (count==FIFO_DEPTH); empty = (count==0).
  - tx_data/tx_valid are driven from registered FIFO state only.
  - tx_data holds stable while tx_valid=1 and tx_ready=0.
- Cycle counter: +1 every cycle when not in reset; 32-bit wrap from 0xFFFFFFFF to 0.
- Reset mid-operation: FIFO contents are discarded (pointers cleared); the pending byte is lost; tx_valid drops the cycle after resetn is sampled low.

Optional Feature:
- Macro: SC_DMEM_CYCLE_COUNTER_EN.
- Defined: CYCLES register implemented as above.
- Undefined: no counter flops; CYCLES reads 0 and writes are ignored.
- All other behaviour is identical in both builds.

Decomposition:
- Shared package sc_mmio_pkg holds:
  - Region codes: REGION_RAM=4'h0, REGION_IO=4'hF.
  - I/O register indices: IO_TXDATA=2'd0, IO_STATUS=2'd1, IO_CYCLES=2'd2, IO_LED=2'd3.
  - STATUS bit positions.
- One sub-module, sc_tx_fifo: parameterised synchronous FIFO with push/pop, head, full, empty and push_accepted.
- Decode, RAM, LED and counter logic stay in the top module.

Test Plan:
- RAM: write 0xDEADBEEF to 0x00000010, then read 0x00000010 and 0x00000012 -> both return 0xDEADBEEF; same-cycle read of 0x10 during the write -> old value.
- TX drain: tx_ready=0, push 0x41, 0x42 -> tx_valid=1 and tx_data=0x41 held; raise tx_ready -> 0x41 then 0x42 on consecutive cycles, then tx_valid=0.
- Overflow: tx_ready=0, push 5 bytes -> STATUS reads 0x0000000C (overflow, full); write STATUS -> reads 0x00000004; fifth byte is never emitted.
- Full with simultaneous pop: FIFO full, tx_ready=1, push 0x55 -> accepted, overflow stays 0, 0x55 emitted fourth in order.
- Counter: after reset, read CYCLES at cycle 10 -> 10; write CYCLES -> next read 1 cycle later returns 1; undefined-macro build -> always 0.
- Mid-operation reset: 3 bytes queued, resetn low one cycle -> tx_valid=0, led=0, STATUS=0x00000002, previously written RAM word unchanged.

Source files
------------

// File: rtl/sc_mmio_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sc_mmio_pkg: address-map constants and STATUS packing for the data   |
// | memory / MMIO stage.                Revision: 1.0                    |
// +----------------------------------------------------------------------+
package sc_mmio_pkg;

   localparam logic [3:0] REGION_RAM = 4'h0;
   localparam logic [3:0] REGION_IO  = 4'hF;

   localparam logic [1:0] IO_TXDATA = 2'd0;
   localparam logic [1:0] IO_STATUS = 2'd1;
   localparam logic [1:0] IO_CYCLES = 2'd2;
   localparam logic [1:0] IO_LED    = 2'd3;

   localparam int ST_EMPTY_BIT    = 1;
   localparam int ST_FULL_BIT     = 2;
   localparam int ST_OVERFLOW_BIT = 3;

   function automatic logic [31:0] status_word(input logic overflow, input logic full,
                                               input logic empty);
      logic [31:0] w;
      w                  = '0;
      w[ST_OVERFLOW_BIT] = overflow;
      w[ST_FULL_BIT]     = full;
      w[ST_EMPTY_BIT]    = empty;
      return w;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sc_tx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sc_tx_fifo: synchronous byte FIFO; head reads 0 while empty.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module sc_tx_fifo #(
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic       push,
   input  logic [7:0] push_data,
   input  logic       pop,
   output logic [7:0] head,
   output logic       full,
   output logic       empty,
   output logic       push_accepted
);
   localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
   localparam logic [AW:0] CNT_ONE = {{AW{1'b0}}, 1'b1};

   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [AW:0]   count_q, count_d;
   logic          do_pop;

   always_comb begin
      full          = (count_q == DEPTH_L);
      empty         = (count_q == '0);
      do_pop        = pop & ~empty;
      // A pop frees the slot in the same edge, so a full FIFO can still take a push.
      push_accepted = push & (~full | do_pop);
      wr_d          = wr_q + AW'(push_accepted);
      rd_d          = rd_q + AW'(do_pop);
      count_d       = count_q;
      case ({push_accepted, do_pop})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
      head = empty ? 8'h00 : mem_q[rd_q];
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else begin
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clock) begin
      if (push_accepted) mem_q[wr_q] <= push_data;
   end

endmodule
`default_nettype wire

// File: rtl/sc_dmem_mmio.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sc_dmem_mmio: single-cycle data RAM plus MMIO (TX FIFO, STATUS,      |
// | CYCLES, LED). Macro SC_DMEM_CYCLE_COUNTER_EN enables CYCLES.          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module sc_dmem_mmio
   import sc_mmio_pkg::*;
#(
   parameter int RAM_AW     = 10,
   parameter int FIFO_DEPTH = 4,
   parameter int FIFO_AW    = 2
) (
   input  logic        clock,
   input  logic        resetn,
   input  logic [31:0] addr,
   input  logic [31:0] datain,
   input  logic        we,
   output logic [31:0] dataout,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic [7:0]  led
);
   logic [31:0]       ram_q [2**RAM_AW];
   logic [RAM_AW-1:0] ram_idx;
   logic [1:0]        io_reg;
   logic              sel_ram, sel_io, sel_tx, sel_status, sel_cyc, sel_led;
   logic              push_req, push_accepted, fifo_full, fifo_empty, pop;
   logic [7:0]        fifo_head;
   logic [7:0]        led_q, led_d;
   logic              ovf_q, ovf_d;
   logic [31:0]       cycles_rd;
   logic              unused_addr;

   assign unused_addr = ^addr;

   always_comb begin
      ram_idx    = addr[RAM_AW+1:2];
      io_reg     = addr[3:2];
      sel_ram    = (addr[31:28] == REGION_RAM);
      sel_io     = (addr[31:28] == REGION_IO);
      sel_tx     = sel_io & (io_reg == IO_TXDATA);
      sel_status = sel_io & (io_reg == IO_STATUS);
      sel_cyc    = sel_io & (io_reg == IO_CYCLES);
      sel_led    = sel_io & (io_reg == IO_LED);
      push_req   = we & sel_tx;
      pop        = tx_valid & tx_ready;
      led_d      = (we & sel_led) ? datain[7:0] : led_q;
      ovf_d      = ovf_q;
      if (we & sel_status)                ovf_d = 1'b0;
      else if (push_req & ~push_accepted) ovf_d = 1'b1;
   end

   sc_tx_fifo #(
      .DEPTH(FIFO_DEPTH),
      .AW   (FIFO_AW)
   ) u_tx_fifo (
      .clock        (clock),
      .resetn       (resetn),
      .push         (push_req),
      .push_data    (datain[7:0]),
      .pop          (pop),
      .head         (fifo_head),
      .full         (fifo_full),
      .empty        (fifo_empty),
      .push_accepted(push_accepted)
   );

   assign tx_valid = ~fifo_empty;
   assign tx_data  = fifo_head;
   assign led      = led_q;

`ifdef SC_DMEM_CYCLE_COUNTER_EN
   logic [31:0] cycles_q, cycles_d;

   always_comb begin
      // A software write wins over the increment for that edge.
      cycles_d = (we & sel_cyc) ? 32'h0 : cycles_q + 32'h1;
   end

   always_ff @(posedge clock) begin
      if (!resetn) cycles_q <= '0;
      else         cycles_q <= cycles_d;
   end

   assign cycles_rd = cycles_q;
`else
   logic unused_cyc;
   assign unused_cyc = sel_cyc;
   assign cycles_rd  = 32'h0;
`endif

   always_ff @(posedge clock) begin
      if (!resetn) begin
         led_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         led_q <= led_d;
         ovf_q <= ovf_d;
      end
   end

   // Loads see the pre-edge word even when a store to it is in flight.
   always_ff @(posedge clock) begin
      if (we & sel_ram) ram_q[ram_idx] <= datain;
   end

   always_comb begin
      dataout = '0;
      if (sel_ram) begin
         dataout = ram_q[ram_idx];
      end else if (sel_io) begin
         case (io_reg)
            IO_TXDATA: dataout = {24'h0, fifo_head};
            IO_STATUS: dataout = status_word(ovf_q, fifo_full, fifo_empty);
            IO_CYCLES: dataout = cycles_rd;
            IO_LED:    dataout = {24'h0, led_q};
            default:   dataout = '0;
         endcase
      end
   end

endmodule
`default_nettype wire
